// File: rtl/ex_mem_wb_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_wb_pipe_pkg
// Shared constants for the EX/MEM and MEM/WB pipeline register slice.
//   DEF_DATA_W     : default datapath width (ALU result / memory data)
//   DEF_REG_ADDR_W : default register index width
//   DEF_CNT_W      : default bubble counter width
//   X0_IDX         : index of the hard-wired zero register
// ---------------------------------------------------------------------------
package ex_mem_wb_pipe_pkg;

    localparam int DEF_DATA_W     = 64;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_CNT_W      = 32;
    localparam int X0_IDX         = 0;

endpackage : ex_mem_wb_pipe_pkg

// File: rtl/ex_mem_wb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Generic pipeline stage register.
//   clk    : core clock
//   arst_n : asynchronous active-low reset, clears q
//   en     : load d into q on the rising edge
//   clr    : synchronous clear to zero (wins over en)
//   d      : next stage contents
//   q      : registered stage contents
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : pipe_stage_reg

// File: rtl/ex_mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// ex_mem_wb_pipe
// EX/MEM and MEM/WB pipeline registers, forwarding sources, load-use hazard
// detection and a saturating count of bubbles entering MEM/WB.
//   clk, arst_n            : clock, asynchronous active-low reset
//   stall                  : hold both stages
//   flush_ex_mem           : load a bubble into EX/MEM (wins over stall there)
//   ex_*                   : EX-stage instruction fields
//   mem_rdata              : data memory read data during MEM
//   id_rs1, id_rs2         : ID-stage source registers for hazard check
//   bubble_cnt_clr         : synchronous clear of bubble_cnt
//   *_EX_MEM               : EX/MEM stage outputs (forwarding source)
//   *_MEM_WB               : MEM/WB stage outputs (register file write port)
//   load_use_stall         : ID must stall one cycle
//   bubble_cnt             : saturating count of bubbles entering MEM/WB
// ---------------------------------------------------------------------------
module ex_mem_wb_pipe
    import ex_mem_wb_pipe_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  stall,
    input  logic                  flush_ex_mem,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_2_reg,
    input  logic [DATA_W-1:0]     ex_alu_result,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  bubble_cnt_clr,
    output logic                  reg_write_EX_MEM,
    output logic [REG_ADDR_W-1:0] RegisterRD_EX_MEM,
    output logic [DATA_W-1:0]     alu_result_EX_MEM,
    output logic                  mem_read_EX_MEM,
    output logic                  reg_write_MEM_WB,
    output logic [REG_ADDR_W-1:0] RegisterRD_MEM_WB,
    output logic [DATA_W-1:0]     wb_data_MEM_WB,
    output logic                  load_use_stall,
    output logic [CNT_W-1:0]      bubble_cnt
);

    localparam int EXM_W = 4 + REG_ADDR_W + DATA_W;
    localparam int MWB_W = 1 + REG_ADDR_W + DATA_W;

    logic                  ex_rd_nz;
    logic                  ex_mem_valid;
    logic                  ex_mem_2_reg_q;
    logic [EXM_W-1:0]      ex_mem_d;
    logic [EXM_W-1:0]      ex_mem_q;
    logic [MWB_W-1:0]      mem_wb_d;
    logic [MWB_W-1:0]      mem_wb_q;
    logic [DATA_W-1:0]     wb_sel;

    // x0 is never reported as a destination, so it is never forwarded.
    assign ex_rd_nz = (ex_rd != REG_ADDR_W'(X0_IDX));

    // ---------------- EX/MEM ----------------
    assign ex_mem_d = {ex_valid,
                       ex_reg_write & ex_valid & ex_rd_nz,
                       ex_mem_read  & ex_valid & ex_rd_nz,
                       ex_mem_2_reg,
                       ex_rd,
                       ex_alu_result};

    pipe_stage_reg #(.W(EXM_W)) u_ex_mem (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (!stall),
        .clr    (flush_ex_mem),
        .d      (ex_mem_d),
        .q      (ex_mem_q)
    );

    assign {ex_mem_valid, reg_write_EX_MEM, mem_read_EX_MEM, ex_mem_2_reg_q,
            RegisterRD_EX_MEM, alu_result_EX_MEM} = ex_mem_q;

    // ---------------- MEM/WB ----------------
    // Flush never reaches this stage; only stall holds it.
    assign wb_sel   = ex_mem_2_reg_q ? mem_rdata : alu_result_EX_MEM;
    assign mem_wb_d = {reg_write_EX_MEM, RegisterRD_EX_MEM, wb_sel};

    pipe_stage_reg #(.W(MWB_W)) u_mem_wb (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (!stall),
        .clr    (1'b0),
        .d      (mem_wb_d),
        .q      (mem_wb_q)
    );

    assign {reg_write_MEM_WB, RegisterRD_MEM_WB, wb_data_MEM_WB} = mem_wb_q;

    // ---------------- load-use hazard ----------------
    // NOTE: every combinational output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        load_use_stall = 1'b0;
        if (ex_valid && ex_mem_read && ex_rd_nz &&
            ((ex_rd == id_rs1) || (ex_rd == id_rs2))) begin
            load_use_stall = 1'b1;
        end
    end

    // ---------------- bubble counter ----------------
    // A bubble is counted on the edge where an invalid EX/MEM entry moves
    // into MEM/WB; it sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bubble_cnt <= '0;
        end else if (bubble_cnt_clr) begin
            bubble_cnt <= '0;
        end else if (!stall && !ex_mem_valid && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule : ex_mem_wb_pipe

// File: tb/tb_ex_mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_wb_pipe
// Directed testbench for ex_mem_wb_pipe. A second instance built with a
// 4-bit bubble counter exercises saturation.
// ---------------------------------------------------------------------------
module tb_ex_mem_wb_pipe;

    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 32;

    logic                  clk = 1'b0;
    logic                  arst_n;
    logic                  stall;
    logic                  flush_ex_mem;
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_2_reg;
    logic [DATA_W-1:0]     ex_alu_result;
    logic [DATA_W-1:0]     mem_rdata;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  bubble_cnt_clr;
    logic                  clr4;

    logic                  reg_write_EX_MEM;
    logic [REG_ADDR_W-1:0] RegisterRD_EX_MEM;
    logic [DATA_W-1:0]     alu_result_EX_MEM;
    logic                  mem_read_EX_MEM;
    logic                  reg_write_MEM_WB;
    logic [REG_ADDR_W-1:0] RegisterRD_MEM_WB;
    logic [DATA_W-1:0]     wb_data_MEM_WB;
    logic                  load_use_stall;
    logic [CNT_W-1:0]      bubble_cnt;

    logic                  rw_exm4;
    logic [REG_ADDR_W-1:0] rd_exm4;
    logic [DATA_W-1:0]     alu_exm4;
    logic                  mr_exm4;
    logic                  rw_mwb4;
    logic [REG_ADDR_W-1:0] rd_mwb4;
    logic [DATA_W-1:0]     wb_mwb4;
    logic                  lus4;
    logic [3:0]            cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_wb_pipe #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .arst_n            (arst_n),
        .stall             (stall),
        .flush_ex_mem      (flush_ex_mem),
        .ex_valid          (ex_valid),
        .ex_rd             (ex_rd),
        .ex_reg_write      (ex_reg_write),
        .ex_mem_read       (ex_mem_read),
        .ex_mem_2_reg      (ex_mem_2_reg),
        .ex_alu_result     (ex_alu_result),
        .mem_rdata         (mem_rdata),
        .id_rs1            (id_rs1),
        .id_rs2            (id_rs2),
        .bubble_cnt_clr    (bubble_cnt_clr),
        .reg_write_EX_MEM  (reg_write_EX_MEM),
        .RegisterRD_EX_MEM (RegisterRD_EX_MEM),
        .alu_result_EX_MEM (alu_result_EX_MEM),
        .mem_read_EX_MEM   (mem_read_EX_MEM),
        .reg_write_MEM_WB  (reg_write_MEM_WB),
        .RegisterRD_MEM_WB (RegisterRD_MEM_WB),
        .wb_data_MEM_WB    (wb_data_MEM_WB),
        .load_use_stall    (load_use_stall),
        .bubble_cnt        (bubble_cnt)
    );

    ex_mem_wb_pipe #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(4)) dut4 (
        .clk               (clk),
        .arst_n            (arst_n),
        .stall             (stall),
        .flush_ex_mem      (flush_ex_mem),
        .ex_valid          (ex_valid),
        .ex_rd             (ex_rd),
        .ex_reg_write      (ex_reg_write),
        .ex_mem_read       (ex_mem_read),
        .ex_mem_2_reg      (ex_mem_2_reg),
        .ex_alu_result     (ex_alu_result),
        .mem_rdata         (mem_rdata),
        .id_rs1            (id_rs1),
        .id_rs2            (id_rs2),
        .bubble_cnt_clr    (clr4),
        .reg_write_EX_MEM  (rw_exm4),
        .RegisterRD_EX_MEM (rd_exm4),
        .alu_result_EX_MEM (alu_exm4),
        .mem_read_EX_MEM   (mr_exm4),
        .reg_write_MEM_WB  (rw_mwb4),
        .RegisterRD_MEM_WB (rd_mwb4),
        .wb_data_MEM_WB    (wb_mwb4),
        .load_use_stall    (lus4),
        .bubble_cnt        (cnt4)
    );

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 1'b0; flush_ex_mem = 1'b0; ex_valid = 1'b0; ex_rd = '0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_2_reg = 1'b0;
        ex_alu_result = '0; mem_rdata = '0; id_rs1 = '0; id_rs2 = '0;
        bubble_cnt_clr = 1'b0; clr4 = 1'b0;
    endtask

    task automatic alu_op(input logic [REG_ADDR_W-1:0] rd, input logic [DATA_W-1:0] val);
        ex_valid = 1'b1; ex_rd = rd; ex_reg_write = 1'b1; ex_mem_read = 1'b0;
        ex_mem_2_reg = 1'b0; ex_alu_result = val;
    endtask

    task automatic test_reset();
        idle();
        arst_n = 1'b1;
        #1 arst_n = 1'b0;
        #1;
        checks++; if (reg_write_EX_MEM !== 1'b0) begin errors++; $display("FAIL rst_rw_exm got=%0h exp=0", reg_write_EX_MEM); end
        checks++; if (RegisterRD_EX_MEM !== 5'd0) begin errors++; $display("FAIL rst_rd_exm got=%0h exp=0", RegisterRD_EX_MEM); end
        checks++; if (alu_result_EX_MEM !== 64'd0) begin errors++; $display("FAIL rst_alu_exm got=%0h exp=0", alu_result_EX_MEM); end
        checks++; if (mem_read_EX_MEM !== 1'b0) begin errors++; $display("FAIL rst_mr_exm got=%0h exp=0", mem_read_EX_MEM); end
        checks++; if (reg_write_MEM_WB !== 1'b0) begin errors++; $display("FAIL rst_rw_mwb got=%0h exp=0", reg_write_MEM_WB); end
        checks++; if (RegisterRD_MEM_WB !== 5'd0) begin errors++; $display("FAIL rst_rd_mwb got=%0h exp=0", RegisterRD_MEM_WB); end
        checks++; if (wb_data_MEM_WB !== 64'd0) begin errors++; $display("FAIL rst_wb_mwb got=%0h exp=0", wb_data_MEM_WB); end
        checks++; if (bubble_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got=%0h exp=0", bubble_cnt); end
        #6 arst_n = 1'b1;   // release between edges
    endtask

    task automatic test_back_to_back();
        alu_op(5'd5, 64'h1234);
        tick();
        checks++; if (RegisterRD_EX_MEM !== 5'd5) begin errors++; $display("FAIL b2b_rd_exm got=%0h exp=5", RegisterRD_EX_MEM); end
        checks++; if (reg_write_EX_MEM !== 1'b1) begin errors++; $display("FAIL b2b_rw_exm got=%0h exp=1", reg_write_EX_MEM); end
        checks++; if (alu_result_EX_MEM !== 64'h1234) begin errors++; $display("FAIL b2b_alu_exm got=%0h exp=1234", alu_result_EX_MEM); end
        alu_op(5'd6, 64'h55);
        tick();
        checks++; if (RegisterRD_MEM_WB !== 5'd5) begin errors++; $display("FAIL b2b_rd_mwb got=%0h exp=5", RegisterRD_MEM_WB); end
        checks++; if (wb_data_MEM_WB !== 64'h1234) begin errors++; $display("FAIL b2b_wb_mwb got=%0h exp=1234", wb_data_MEM_WB); end
        checks++; if (reg_write_MEM_WB !== 1'b1) begin errors++; $display("FAIL b2b_rw_mwb got=%0h exp=1", reg_write_MEM_WB); end
        checks++; if (RegisterRD_EX_MEM !== 5'd6) begin errors++; $display("FAIL b2b_rd2_exm got=%0h exp=6", RegisterRD_EX_MEM); end
        idle();
        tick();
        checks++; if (RegisterRD_MEM_WB !== 5'd6) begin errors++; $display("FAIL b2b_rd2_mwb got=%0h exp=6", RegisterRD_MEM_WB); end
        checks++; if (wb_data_MEM_WB !== 64'h55) begin errors++; $display("FAIL b2b_wb2_mwb got=%0h exp=55", wb_data_MEM_WB); end
    endtask

    task automatic test_load();
        ex_valid = 1'b1; ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        ex_mem_2_reg = 1'b1; ex_alu_result = 64'h999; id_rs1 = 5'd3; id_rs2 = 5'd7;
        #1;
        checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lus_rs2 got=%0h exp=1", load_use_stall); end
        id_rs2 = 5'd3;
        #1;
        checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lus_nomatch got=%0h exp=0", load_use_stall); end
        tick();
        idle();
        mem_rdata = 64'hDEAD;
        checks++; if (mem_read_EX_MEM !== 1'b1) begin errors++; $display("FAIL ld_mr_exm got=%0h exp=1", mem_read_EX_MEM); end
        tick();
        mem_rdata = '0;
        checks++; if (wb_data_MEM_WB !== 64'hDEAD) begin errors++; $display("FAIL ld_wb got=%0h exp=dead", wb_data_MEM_WB); end
        checks++; if (RegisterRD_MEM_WB !== 5'd7) begin errors++; $display("FAIL ld_rd_mwb got=%0h exp=7", RegisterRD_MEM_WB); end
        checks++; if (reg_write_MEM_WB !== 1'b1) begin errors++; $display("FAIL ld_rw_mwb got=%0h exp=1", reg_write_MEM_WB); end
    endtask

    task automatic test_x0();
        alu_op(5'd0, 64'hAB);
        tick();
        checks++; if (reg_write_EX_MEM !== 1'b0) begin errors++; $display("FAIL x0_rw_exm got=%0h exp=0", reg_write_EX_MEM); end
        idle();
        tick();
        checks++; if (reg_write_MEM_WB !== 1'b0) begin errors++; $display("FAIL x0_rw_mwb got=%0h exp=0", reg_write_MEM_WB); end
        ex_valid = 1'b1; ex_rd = 5'd0; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        ex_mem_2_reg = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0;
        #1;
        checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL x0_lus got=%0h exp=0", load_use_stall); end
        tick();
        checks++; if (mem_read_EX_MEM !== 1'b0) begin errors++; $display("FAIL x0_mr_exm got=%0h exp=0", mem_read_EX_MEM); end
        ex_valid = 1'b0; ex_rd = 5'd7; id_rs1 = 5'd7;
        #1;
        checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lus_invalid got=%0h exp=0", load_use_stall); end
        idle();
    endtask

    task automatic test_stall();
        alu_op(5'd9, 64'h9);
        bubble_cnt_clr = 1'b1;
        tick();
        bubble_cnt_clr = 1'b0;
        alu_op(5'd10, 64'hA);
        tick();
        stall = 1'b1;
        alu_op(5'd11, 64'hB);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (RegisterRD_EX_MEM !== 5'd10 || alu_result_EX_MEM !== 64'hA || reg_write_EX_MEM !== 1'b1)
                begin errors++; $display("FAIL stall_exm[%0d] got rd=%0h alu=%0h rw=%0h exp rd=a alu=a rw=1", i, RegisterRD_EX_MEM, alu_result_EX_MEM, reg_write_EX_MEM); end
            checks++; if (RegisterRD_MEM_WB !== 5'd9 || wb_data_MEM_WB !== 64'h9 || reg_write_MEM_WB !== 1'b1)
                begin errors++; $display("FAIL stall_mwb[%0d] got rd=%0h wb=%0h rw=%0h exp rd=9 wb=9 rw=1", i, RegisterRD_MEM_WB, wb_data_MEM_WB, reg_write_MEM_WB); end
            checks++; if (bubble_cnt !== 32'd0) begin errors++; $display("FAIL stall_cnt[%0d] got=%0h exp=0", i, bubble_cnt); end
        end
        flush_ex_mem = 1'b1;
        tick();
        checks++; if (reg_write_EX_MEM !== 1'b0 || RegisterRD_EX_MEM !== 5'd0 || alu_result_EX_MEM !== 64'd0)
            begin errors++; $display("FAIL fls_exm got rw=%0h rd=%0h alu=%0h exp all 0", reg_write_EX_MEM, RegisterRD_EX_MEM, alu_result_EX_MEM); end
        checks++; if (RegisterRD_MEM_WB !== 5'd9 || wb_data_MEM_WB !== 64'h9)
            begin errors++; $display("FAIL fls_mwb_hold got rd=%0h wb=%0h exp rd=9 wb=9", RegisterRD_MEM_WB, wb_data_MEM_WB); end
        checks++; if (bubble_cnt !== 32'd0) begin errors++; $display("FAIL fls_cnt got=%0h exp=0", bubble_cnt); end
        idle();
        tick();
        checks++; if (reg_write_MEM_WB !== 1'b0 || RegisterRD_MEM_WB !== 5'd0 || wb_data_MEM_WB !== 64'd0)
            begin errors++; $display("FAIL fls_bubble_mwb got rw=%0h rd=%0h wb=%0h exp all 0", reg_write_MEM_WB, RegisterRD_MEM_WB, wb_data_MEM_WB); end
        checks++; if (bubble_cnt !== 32'd1) begin errors++; $display("FAIL fls_bubble_cnt got=%0h exp=1", bubble_cnt); end
    endtask

    task automatic test_flush_count();
        logic [31:0] exp_cnt [4];
        exp_cnt[0] = 32'd0; exp_cnt[1] = 32'd1; exp_cnt[2] = 32'd2; exp_cnt[3] = 32'd3;
        alu_op(5'd12, 64'hC);
        bubble_cnt_clr = 1'b1;
        tick();
        bubble_cnt_clr = 1'b0;
        flush_ex_mem = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bubble_cnt !== exp_cnt[i]) begin errors++; $display("FAIL flush_cnt[%0d] got=%0h exp=%0h", i, bubble_cnt, exp_cnt[i]); end
        end
        flush_ex_mem = 1'b0;
        alu_op(5'd12, 64'hC);
        tick();
        checks++; if (bubble_cnt !== 32'd4) begin errors++; $display("FAIL flush_cnt_last got=%0h exp=4", bubble_cnt); end
        idle();
        tick();
        checks++; if (bubble_cnt !== 32'd4) begin errors++; $display("FAIL flush_cnt_valid got=%0h exp=4", bubble_cnt); end
        bubble_cnt_clr = 1'b1;
        tick();
        bubble_cnt_clr = 1'b0;
        checks++; if (bubble_cnt !== 32'd0) begin errors++; $display("FAIL clr_vs_bubble got=%0h exp=0", bubble_cnt); end
    endtask

    task automatic test_saturation();
        idle();
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        checks++; if (cnt4 !== 4'd14) begin errors++; $display("FAIL sat_pre got=%0h exp=e", cnt4); end
        tick();
        checks++; if (cnt4 !== 4'd15) begin errors++; $display("FAIL sat_top got=%0h exp=f", cnt4); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (cnt4 !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0h exp=f", cnt4); end
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        checks++; if (cnt4 !== 4'd0) begin errors++; $display("FAIL sat_clr got=%0h exp=0", cnt4); end
    endtask

    task automatic test_reset_mid();
        alu_op(5'd13, 64'h77);
        tick();
        alu_op(5'd14, 64'h88);
        tick();
        #3 arst_n = 1'b0;
        #1;
        checks++; if (reg_write_EX_MEM !== 1'b0 || RegisterRD_EX_MEM !== 5'd0 || alu_result_EX_MEM !== 64'd0 || mem_read_EX_MEM !== 1'b0)
            begin errors++; $display("FAIL mid_rst_exm got rw=%0h rd=%0h alu=%0h mr=%0h exp all 0", reg_write_EX_MEM, RegisterRD_EX_MEM, alu_result_EX_MEM, mem_read_EX_MEM); end
        checks++; if (reg_write_MEM_WB !== 1'b0 || RegisterRD_MEM_WB !== 5'd0 || wb_data_MEM_WB !== 64'd0)
            begin errors++; $display("FAIL mid_rst_mwb got rw=%0h rd=%0h wb=%0h exp all 0", reg_write_MEM_WB, RegisterRD_MEM_WB, wb_data_MEM_WB); end
        checks++; if (bubble_cnt !== 32'd0 || cnt4 !== 4'd0)
            begin errors++; $display("FAIL mid_rst_cnt got=%0h/%0h exp=0/0", bubble_cnt, cnt4); end
        #2 arst_n = 1'b1;
        alu_op(5'd15, 64'h42);
        tick();
        checks++; if (RegisterRD_EX_MEM !== 5'd15 || alu_result_EX_MEM !== 64'h42 || reg_write_EX_MEM !== 1'b1)
            begin errors++; $display("FAIL post_rst_exm got rd=%0h alu=%0h rw=%0h exp rd=f alu=42 rw=1", RegisterRD_EX_MEM, alu_result_EX_MEM, reg_write_EX_MEM); end
        checks++; if (reg_write_MEM_WB !== 1'b0) begin errors++; $display("FAIL post_rst_mwb got=%0h exp=0", reg_write_MEM_WB); end
        idle();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load();
        test_x0();
        test_stall();
        test_flush_count();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ex_mem_wb_pipe
